// File: rtl/sd_cmd_sniffer.sv
`default_nettype none
// ============================================================================
// sd_cmd_sniffer : passive SD CMD-line frame capture, CRC7 check, show-ahead FIFO
// Rev 1.0
// ============================================================================
module sd_cmd_sniffer #(
  parameter int FIFO_DEPTH = 16,
  parameter int LONG_EN    = 1,
  parameter int CRC_DROP   = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sdclk,
  input  logic         sdcmd,
  input  logic         arm_long,
  input  logic         cnt_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [135:0] out_frame,
  output logic         out_long,
  output logic         out_crc_ok,
  output logic [15:0]  drop_cnt,
  output logic [15:0]  err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BODY = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_nxt;
  logic [1:0]     sclk_sync, scmd_sync;
  logic           sclk_prev;
  logic           strobe, bit_in;
  logic [135:0]   shreg;
  logic [7:0]     bit_cnt, bit_cnt_nxt, frame_len;
  logic           is_long, long_sel, arm;
  logic [6:0]     crc_s, crc_l;
  logic [TW-1:0]  to_cnt;
  logic           start_frame, shift_en, abort, frame_end;
  logic           crc_ok, push_req, push, pop, drop_inc, err_inc;
  logic [135:0]   push_data;
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           empty, full;
  logic [137:0]   mem [FIFO_DEPTH];
  logic [137:0]   head;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      scmd_sync <= 2'b11;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sdclk};
      scmd_sync <= {scmd_sync[0], sdcmd};
      sclk_prev <= sclk_sync[1];
    end
  end

  assign strobe = sclk_sync[1] & ~sclk_prev;
  assign bit_in = scmd_sync[1];

  // Length is decided on the transmission bit (bit_cnt==1); afterwards it is held.
  assign long_sel    = (bit_cnt == 8'd1) ? ((LONG_EN != 0) && arm && !bit_in) : is_long;
  assign frame_len   = long_sel ? 8'd136 : 8'd48;
  assign bit_cnt_nxt = bit_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    abort       = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (strobe && !bit_in) begin
          start_frame = 1'b1;
          state_nxt   = BODY;
        end
      end
      BODY: begin
        if (strobe) begin
          shift_en = 1'b1;
          if (bit_cnt_nxt == frame_len) state_nxt = DONE;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        frame_end = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Two running CRCs: short frames cover arrival bits 0..39, R2 covers 8..127.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      is_long <= 1'b0;
      crc_s   <= '0;
      crc_l   <= '0;
      to_cnt  <= '0;
    end else if (start_frame) begin
      shreg   <= {shreg[134:0], bit_in};
      bit_cnt <= 8'd1;
      is_long <= 1'b0;
      crc_s   <= crc7_step(7'd0, bit_in);
      crc_l   <= '0;
      to_cnt  <= '0;
    end else if (shift_en) begin
      shreg   <= {shreg[134:0], bit_in};
      bit_cnt <= bit_cnt_nxt;
      is_long <= long_sel;
      if (bit_cnt < 8'd40) crc_s <= crc7_step(crc_s, bit_in);
      if (bit_cnt >= 8'd8 && bit_cnt < 8'd128) crc_l <= crc7_step(crc_l, bit_in);
      to_cnt  <= '0;
    end else if (state == BODY) begin
      to_cnt  <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      arm <= 1'b0;
    else if (arm_long)                               arm <= 1'b1;
    else if (shift_en && bit_cnt == 8'd1 && !bit_in) arm <= 1'b0;
  end

  assign crc_ok    = ((is_long ? crc_l : crc_s) == shreg[7:1]);
  assign push_req  = frame_end && shreg[0] && (crc_ok || (CRC_DROP == 0));
  assign err_inc   = abort || (frame_end && (!shreg[0] || (!crc_ok && (CRC_DROP != 0))));
  assign push_data = is_long ? shreg : {88'd0, shreg[47:0]};

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop      = !empty && out_ready;
  assign push     = push_req && (!full || pop);
  assign drop_inc = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {is_long, crc_ok, push_data};
  end

  // Outputs are gated so that an empty FIFO presents all zeros.
  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_valid  = !empty;
  assign out_frame  = empty ? 136'd0 : head[135:0];
  assign out_long   = !empty && head[137];
  assign out_crc_ok = !empty && head[136];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (cnt_clr)                            drop_cnt <= '0;
      else if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (cnt_clr)                            err_cnt  <= '0;
      else if (err_inc && err_cnt != 16'hFFFF)   err_cnt  <= err_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sniffer.sv
`default_nettype none
// ============================================================================
// tb_sd_cmd_sniffer : randomized bench with a frame-level reference model
// Rev 1.0
// ============================================================================
module tb_sd_cmd_sniffer;

  localparam int DEPTH = 16;
  localparam int TMO   = 1024;

  logic clk = 1'b0, rst_n = 1'b0, sdclk = 1'b0, sdcmd = 1'b1;
  logic arm_long = 1'b0, cnt_clr = 1'b0, out_ready = 1'b0;
  logic v0, v1, l0, l1, k0, k1;
  logic [135:0] f0, f1;
  logic [15:0] d0, d1, e0, e1;

  always #5 clk = ~clk;

  sd_cmd_sniffer #(.FIFO_DEPTH(DEPTH), .LONG_EN(1), .CRC_DROP(0), .TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n), .sdclk(sdclk), .sdcmd(sdcmd), .arm_long(arm_long),
    .cnt_clr(cnt_clr), .out_valid(v0), .out_ready(out_ready), .out_frame(f0),
    .out_long(l0), .out_crc_ok(k0), .drop_cnt(d0), .err_cnt(e0));

  sd_cmd_sniffer #(.FIFO_DEPTH(DEPTH), .LONG_EN(1), .CRC_DROP(1), .TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst_n(rst_n), .sdclk(sdclk), .sdcmd(sdcmd), .arm_long(arm_long),
    .cnt_clr(cnt_clr), .out_valid(v1), .out_ready(out_ready), .out_frame(f1),
    .out_long(l1), .out_crc_ok(k1), .drop_cnt(d1), .err_cnt(e1));

  typedef struct packed { logic lng; logic ok; logic [135:0] f; } ent_t;

  ent_t q0[$], q1[$];
  ent_t h0, h1;
  int   total = 0, bad = 0;
  int   mdrop0 = 0, mdrop1 = 0, merr0 = 0, merr1 = 0;
  bit   marm = 1'b0, mon_en = 1'b0;
  int   ready_mode = 1;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // CRC7 by polynomial long division of data*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc_ref(input logic [135:0] d, input int nb);
    logic [142:0] v;
    v = {d, 7'b0};
    for (int i = nb + 6; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [135:0] mk48(input bit trans, input logic [37:0] body);
    logic [39:0] p;
    p = {1'b0, trans, body};
    return {88'd0, p, crc_ref({96'd0, p}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk136(input logic [119:0] cid);
    return {8'h3F, cid, crc_ref({16'd0, cid}, 120), 1'b1};
  endfunction

  function automatic logic [119:0] rnd120();
    logic [119:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r = {r[87:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [37:0] rnd38();
    return 38'({$urandom(), $urandom()});
  endfunction

  task automatic model_push(input int id, input ent_t e);
    if (id == 0) begin
      if (q0.size() >= DEPTH) mdrop0++; else q0.push_back(e);
    end else begin
      if (q1.size() >= DEPTH) mdrop1++; else q1.push_back(e);
    end
  endtask

  // Applies the frame rules to a complete frame of n bits (n must match the arm state).
  task automatic model_frame(input logic [135:0] f, input int n);
    bit trans, lng, ok;
    logic [135:0] d;
    ent_t e;
    trans = f[n-2];
    lng   = marm && !trans;
    if (!trans) marm = 1'b0;
    d  = (f >> 8) & ((136'd1 << (lng ? 120 : 40)) - 136'd1);
    ok = (crc_ref(d, lng ? 120 : 40) == f[7:1]);
    e.lng = lng;
    e.ok  = ok;
    e.f   = lng ? f : {88'd0, f[47:0]};
    if (!f[0]) begin
      merr0++; merr1++;
    end else begin
      model_push(0, e);
      if (ok) model_push(1, e); else merr1++;
    end
  endtask

  // Sends bits n-1 .. n-nsend; low and high phases of h clk cycles each.
  task automatic send(input logic [135:0] f, input int n, input int nsend, input int h,
                      input bit chk_lat);
    @(posedge clk); #1;
    for (int i = n - 1; i >= n - nsend; i--) begin
      sdclk = 1'b0;
      sdcmd = f[i];
      repeat (h) @(posedge clk);
      #1;
      if (i == 0) model_frame(f, n);
      sdclk = 1'b1;
      if (chk_lat && i == 0) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lat_early", v0, 0);
        @(posedge clk);
        @(negedge clk);
        check("lat_valid", v0, 1);
        check("cmd0_frame", f0, 136'h400000000095);
        check("cmd0_long", l0, 0);
        check("cmd0_crc", k0, 1);
        @(posedge clk); #1;
      end else begin
        repeat (h) @(posedge clk);
        #1;
      end
    end
    sdclk = 1'b0;
    sdcmd = 1'b1;
  endtask

  task automatic idle_bits(input int k, input int h);
    for (int i = 0; i < k; i++) begin
      repeat (h) @(posedge clk);
      #1 sdclk = 1'b1;
      repeat (h) @(posedge clk);
      #1 sdclk = 1'b0;
    end
  endtask

  task automatic pulse_arm();
    @(posedge clk); #1 arm_long = 1'b1; marm = 1'b1;
    @(posedge clk); #1 arm_long = 1'b0;
  endtask

  task automatic wait_drain();
    repeat (8) @(posedge clk);
    for (int i = 0; i < 4000 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    check("drain0", 136'(q0.size()), 0);
    check("drain1", 136'(q1.size()), 0);
    check("idle_valid0", v0, 0);
    check("idle_valid1", v1, 0);
  endtask

  task automatic check_cnts(input string tag);
    @(negedge clk);
    check({tag, "_drop0"}, d0, 136'(mdrop0));
    check({tag, "_drop1"}, d1, 136'(mdrop1));
    check({tag, "_err0"}, e0, 136'(merr0));
    check({tag, "_err1"}, e1, 136'(merr1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_v0"}, {v0, l0, k0}, 0);
    check({tag, "_v1"}, {v1, l1, k1}, 0);
    check({tag, "_f0"}, f0, 0);
    check({tag, "_f1"}, f1, 0);
    check({tag, "_c0"}, {d0, e0}, 0);
    check({tag, "_c1"}, {d1, e1}, 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Head of each FIFO must always equal the oldest model entry.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (v0) begin
        if (q0.size() == 0) check("spur0", v0, 0);
        else begin
          h0 = q0[0];
          check("frame0", f0, h0.f);
          check("long0", l0, h0.lng);
          check("crcok0", k0, h0.ok);
          if (out_ready) void'(q0.pop_front());
        end
      end
      if (v1) begin
        if (q1.size() == 0) check("spur1", v1, 0);
        else begin
          h1 = q1[0];
          check("frame1", f1, h1.f);
          check("long1", l1, h1.lng);
          check("crcok1", k1, h1.ok);
          if (out_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    logic [135:0] fr;
    int kind, h;
    ready_mode = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;
    idle_bits(2, 4);

    // CMD0 with exact latency check, then its CRC-corrupted twin.
    send(136'h400000000095, 48, 48, 4, 1'b1);
    send(136'h400000010095, 48, 48, 4, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("crcbad_err0", e0, 0);
    check("crcbad_err1", e1, 1);
    check_cnts("crc");

    // R2 capture; arm survives a host command in between.
    pulse_arm();
    send(mk136(rnd120()), 136, 136, 3, 1'b0);
    send(mk48(1'b0, rnd38()), 48, 48, 3, 1'b0);
    pulse_arm();
    send(mk48(1'b1, rnd38()), 48, 48, 3, 1'b0);
    send(mk136(rnd120()), 136, 136, 3, 1'b0);
    send(mk48(1'b0, rnd38()), 48, 48, 3, 1'b0);
    wait_drain();

    // Overflow with consumer stalled.
    ready_mode = 0;
    for (int i = 0; i < DEPTH + 2; i++) send(mk48(1'b1, rnd38()), 48, 48, 2, 1'b0);
    repeat (10) @(posedge clk);
    check_cnts("ovf");
    check("ovf_drop_abs", d0, 2);
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    mdrop0 = 0; mdrop1 = 0; merr0 = 0; merr1 = 0;
    check_cnts("clr");
    ready_mode = 1;
    wait_drain();

    // Timeout mid-frame, then a clean frame.
    send(mk48(1'b1, rnd38()), 48, 20, 3, 1'b0);
    repeat (TMO + 80) @(posedge clk);
    merr0++; merr1++;
    check_cnts("tmo");
    check("tmo_err_abs", e0, 1);
    send(mk48(1'b1, rnd38()), 48, 48, 3, 1'b0);
    wait_drain();

    // Randomized traffic.
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      h    = $urandom_range(2, 4);
      case (kind)
        0: send(mk48(1'b1, rnd38()), 48, 48, h, 1'b0);
        1: send(mk48(1'b0, rnd38()), 48, 48, h, 1'b0);
        2: begin
          pulse_arm();
          if ($urandom_range(0, 1) == 1) send(mk48(1'b1, rnd38()), 48, 48, h, 1'b0);
          fr = mk136(rnd120());
          if ($urandom_range(0, 3) == 0) fr[$urandom_range(8, 127)] ^= 1'b1;
          send(fr, 136, 136, h, 1'b0);
        end
        3: begin
          fr = mk48(1'($urandom_range(0, 1)), rnd38());
          fr[$urandom_range(8, 46)] ^= 1'b1;
          send(fr, 48, 48, h, 1'b0);
        end
        default: begin
          fr = mk48(1'b1, rnd38());
          fr[0] = 1'b0;
          send(fr, 48, 48, h, 1'b0);
        end
      endcase
      if ($urandom_range(0, 1) == 1) idle_bits($urandom_range(1, 2), h);
    end
    ready_mode = 1;
    wait_drain();
    check_cnts("rnd");

    // Reset in the middle of a frame with an entry queued.
    ready_mode = 0;
    send(mk48(1'b1, rnd38()), 48, 48, 3, 1'b0);
    send(mk48(1'b1, rnd38()), 48, 20, 3, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    q0.delete(); q1.delete();
    mdrop0 = 0; mdrop1 = 0; merr0 = 0; merr1 = 0; marm = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 1;
    send(mk48(1'b1, rnd38()), 48, 48, 3, 1'b0);
    wait_drain();
    check_cnts("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
